// File: rtl/pixel_frame_controller.sv
// Frame sequencer: streams one frame from a source RAM through the pixel
// operator into a destination RAM, tracking RAM latency and the operator register.
module pixel_frame_controller #(
  parameter int PIX_W        = 12,
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode_req,
  output logic              busy,
  output logic              done,
  output logic [1:0]        op_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  op_pixel,
  input  logic [PIX_W-1:0]  op_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_sel_q, op_sel_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s2_vld_q, s2_vld_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic              done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    op_sel_d  = op_sel_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    // Stage 1 absorbs the RAM read latency, stage 2 lines up with the operator register.
    s1_vld_d  = rd_en_q;
    s1_addr_d = rd_addr_q;
    s2_vld_d  = s1_vld_q;
    s2_addr_d = s1_addr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          op_sel_d  = mode_req;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          rd_en_d  = 1'b0;
          s1_vld_d = 1'b0;
          s2_vld_d = 1'b0;
        end else if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d  = IDLE;
          rd_en_d  = 1'b0;
          s1_vld_d = 1'b0;
          s2_vld_d = 1'b0;
        end else if (s2_vld_q && (s2_addr_q == LAST_ADDR)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_sel_q  <= 2'b00;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_sel_q  <= op_sel_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      s2_vld_q  <= s2_vld_d;
      s2_addr_q <= s2_addr_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign op_sel   = op_sel_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign op_pixel = rd_data;
  assign wr_en    = s2_vld_q;
  assign wr_addr  = s2_addr_q;
  assign wr_data  = op_result;

endmodule

// File: doc/pixel_frame_controller.md
# pixel_frame_controller

Frame sequencer for the 12-bit `pixel_operator` datapath. On a start request it latches the requested operator mode and streams one full frame from a source pixel RAM through the operator into a destination RAM. It accounts for the RAM read latency and the operator's one-cycle register, then signals completion. It sits between the frame buffers and `pixel_operator`. It is the only block that drives `Pixel_sel` and `pixel_in`.

## Interface
- `PIX_W`, 12, pixel width; must match the operator.
- `ADDR_W`, 17, frame-buffer address width.
- `FRAME_PIXELS`, 76800, pixels per frame (320x240); legal range 1 to 2^ADDR_W.

- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  frame request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; sampled only while busy.
- `mode_req`  in  2  operator mode, captured at start: 00 pass, 01 subtract, 10 threshold, 11 invert.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the frame's last write.
- `op_sel`  out  2  drives operator `Pixel_sel`; registered.
- `rd_en`  out  1  source RAM read strobe; registered.
- `rd_addr`  out  ADDR_W  source read address; registered.
- `rd_data`  in  PIX_W  source RAM data, valid the cycle after `rd_en`.
- `op_pixel`  out  PIX_W  drives operator `pixel_in`; equals `rd_data` combinationally.
- `op_result`  in  PIX_W  operator `Out_pixel`.
- `wr_en`  out  1  destination write strobe.
- `wr_addr`  out  ADDR_W  destination address.
- `wr_data`  out  PIX_W  equals `op_result`.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE to RUN:** `start`=1 at an edge moves IDLE to RUN.
  - The same edge loads `op_sel`<=`mode_req`, `rd_en`<=1 and `rd_addr`<=0.
  - `abort` is ignored in IDLE; if `start` and `abort` are both high in IDLE, `start` wins.
- **RUN:**
  - `rd_addr` increments by one each cycle.
  - When the issued address is FRAME_PIXELS-1, the next edge clears `rd_en` and enters DRAIN. `rd_addr` holds its value.
  - No wrap-around: the address never exceeds FRAME_PIXELS-1.
- **Write-side pipeline:** a two-stage valid/address shift register follows each read.
  - Stage 1 covers the RAM latency.
  - Stage 2 aligns with the operator register.
  - `wr_en` is the stage-2 valid bit and `wr_addr` is the stage-2 address.
- **DRAIN:** lasts until the stage-2 valid bit has written the last pixel. The following edge pulses `done`=1 for one cycle and returns to IDLE.
- `op_sel` is held constant from start until the next accepted start. It never changes mid-frame, including during DRAIN.
- **`start` while RUN or DRAIN:** ignored and not queued.
- **`abort`=1 in RUN or DRAIN:** the next edge does all of the following.
  - Clears `rd_en` and both pipeline valid bits, so no further `wr_en`.
  - Returns to IDLE with no `done` pulse.
  - `op_sel` holds its value.
- **`reset`** (asynchronous, any state, including mid-frame) clears these outputs immediately: `busy`, `done`, `rd_en` and `wr_en` go to 0; `rd_addr`, `wr_addr` and `op_sel` go to 0; state goes to IDLE. In-flight pixels are discarded.
- **FRAME_PIXELS=1:** RUN lasts one cycle; the sequence is otherwise identical.

## Timing
- Accepting edge E0: `rd_en` is high in cycles 1 to FRAME_PIXELS; read i occurs in cycle 1+i.
- Write i (`wr_en`=1, `wr_addr`=i) occurs in cycle 3+i. Read-to-write latency is 2 cycles.
- `done` is high in cycle FRAME_PIXELS+3 only.
- `busy` is high in cycles 1 to FRAME_PIXELS+2 and low in the `done` cycle.
- A new `start` sampled during the `done` cycle is accepted; its first read follows in the next cycle.
- Throughput: one pixel per cycle. Frame overhead: 3 cycles (start edge, drain, done).

## Test plan
- **Full frame, invert:** FRAME_PIXELS=4, source {0x123,0x000,0xFFF,0x800}, `mode_req`=11, `start` at E0 -> `rd_en` cycles 1-4 with addr 0-3; `wr_en` cycles 3-6 with data {0xEDC,0xFFF,0x000,0x7FF}; `done` cycle 7; `busy` cycles 1-6.
- **Subtract and threshold through the real operator:**
  - mode 01, source {0xFFF,0x100,0xAAA} -> writes {0x555,0x000,0x000}.
  - mode 10, same source -> writes {0xFFF,0x000,0x000}.
- **Mode stability:** `mode_req` changes 01->11 and `start` pulses in cycle 2 -> `op_sel` stays 01 for the whole frame; no second frame starts.
- **Abort:** `abort` in cycle 3 of a 4-pixel frame -> `rd_en` low from cycle 4; at most the write for addr 0 occurs (cycle 3); no `done`; IDLE; a later `start` runs a full frame.
- **Reset mid-frame:** assert `reset` between edges in cycle 4 -> all outputs 0 immediately, without waiting for a clock edge; after release, `start` produces the nominal timing from scenario 1.
- **Boundaries:**
  - FRAME_PIXELS=1 -> a single read in cycle 1, a single write in cycle 3, `done` in cycle 4.
  - Back-to-back: `start` held high -> the second frame's first read is in the cycle after `done`.
